// File: rtl/seq_chunk_comparator_pkg.sv
// Shared definitions for the chunked sequential comparator: FSM states, result codes, and the width helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b01;
  localparam logic [1:0] RES_LT = 2'b10;

  // Width needed to hold a chunk count in the range 0..width/chunk.
  function automatic int calc_cw(input int width, input int chunk);
    return $clog2(width / chunk + 1);
  endfunction

endpackage

// File: rtl/seq_chunk_comparator_chunk_cmp.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/seq_chunk_comparator.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB chunk first, early exit on first difference.
// Optional SIGNED_CMP_EN macro adds a signed_mode input for two's-complement ordering.
module seq_chunk_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = calc_cw(WIDTH, CHUNK)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SIGNED_CMP_EN
  input  logic             signed_mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             agb,
  output logic             alb,
  output logic             aeb,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic             agb_reg, agb_next, alb_reg, alb_next, aeb_reg, aeb_next;
  logic [CW-1:0]    cycles_reg, cycles_next;
  logic             signed_reg, signed_next;

  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic [CHUNK-1:0] a_cmp, b_cmp;
  logic             gt, lt, eq;
  logic [1:0]       res;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
    assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
  end

  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  always_comb begin
    a_cmp = a_chunk[idx_reg];
    b_cmp = b_chunk[idx_reg];
    if (signed_reg && (idx_reg == TOP_IDX)) begin
      a_cmp[CHUNK-1] = ~a_chunk[idx_reg][CHUNK-1];
      b_cmp[CHUNK-1] = ~b_chunk[idx_reg][CHUNK-1];
    end
  end

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a  (a_cmp),
    .b  (b_cmp),
    .gt (gt),
    .lt (lt),
    .eq (eq)
  );

  always_comb begin
    res = RES_EQ;
    unique case (1'b1)
      gt:      res = RES_GT;
      lt:      res = RES_LT;
      eq:      res = RES_EQ;
      default: res = RES_EQ;
    endcase
  end

`ifdef SIGNED_CMP_EN
  wire signed_in = signed_mode;
`else
  wire signed_in = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    idx_next    = idx_reg;
    agb_next    = agb_reg;
    alb_next    = alb_reg;
    aeb_next    = aeb_reg;
    cycles_next = cycles_reg;
    signed_next = signed_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          a_next      = a;
          b_next      = b;
          signed_next = signed_in;
          idx_next    = TOP_IDX;
          agb_next    = 1'b0;
          alb_next    = 1'b0;
          aeb_next    = 1'b0;
          cycles_next = '0;
          state_next  = COMPARE;
        end else begin
          state_next  = IDLE;
        end
      end
      COMPARE: begin
        cycles_next = cycles_reg + CW'(1);
        case (res)
          RES_GT: begin
            agb_next   = 1'b1;
            state_next = DONE;
          end
          RES_LT: begin
            alb_next   = 1'b1;
            state_next = DONE;
          end
          default: begin
            if (idx_reg == '0) begin
              aeb_next   = 1'b1;
              state_next = DONE;
            end else begin
              idx_next   = idx_reg - IW'(1);
            end
          end
        endcase
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      idx_reg    <= '0;
      agb_reg    <= 1'b0;
      alb_reg    <= 1'b0;
      aeb_reg    <= 1'b0;
      cycles_reg <= '0;
      signed_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      idx_reg    <= idx_next;
      agb_reg    <= agb_next;
      alb_reg    <= alb_next;
      aeb_reg    <= aeb_next;
      cycles_reg <= cycles_next;
      signed_reg <= signed_next;
    end
  end

  assign busy   = (state_reg == COMPARE);
  assign done   = (state_reg == DONE);
  assign agb    = agb_reg;
  assign alb    = alb_reg;
  assign aeb    = aeb_reg;
  assign cycles = cycles_reg;

endmodule
